xm_mem_arbiter: RTL and testbench

Shares the single XMakina memory port between two requesters: the CPU controller (port C) and a DMA/debug engine (port D).
- Port C has fixed priority over port D.
- A saturating starvation counter guarantees that port D is eventually served.
- Each access runs as IDLE -> ACCESS -> RESP. Memory latency is variable and is signalled by memReady_i.
- The block sits between xm_controller's memEn/memRW/byteOp outputs and the memory. It supplies the controller's memBusy.

---
 rtl/xm_arb_pkg.sv | 24 ++
 rtl/xm_arb_starve_cnt.sv | 33 +++
 rtl/xm_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_xm_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_arb_pkg.sv
// Shared types and helpers for the XMakina memory-port arbiter.
// Optional access timeout is enabled with the XM_ARB_TIMEOUT_EN macro.
package xm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_C = 1'b0,
      GNT_D = 1'b1
   } arb_grant_e;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   // Port D wins when it is starved, or when port C is not asking.
   function automatic logic d_priority(input logic c_req, input logic d_req, input logic sat);
      return d_req & (sat | ~c_req);
   endfunction

endpackage

// File: rtl/xm_arb_starve_cnt.sv
// Saturating wait counter for port D; sat flags that D must be served next.
module xm_arb_starve_cnt #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt_r;
   logic          sat_s;

   assign sat_s = (cnt_r == CW'(MAX_WAIT));
   assign sat   = sat_s;

   // Count pending cycles, clear on a D grant, hold at MAX_WAIT.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc && !sat_s) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/xm_mem_arbiter.sv
// Two-port (CPU controller C, DMA/debug D) arbiter for the single XMakina memory port.
// Define XM_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles and flag err_o.
module xm_mem_arbiter
   import xm_arb_pkg::*;
#(
   parameter int WORD     = 16,
   parameter int ADDR     = 16,
   parameter int MAX_WAIT = 8
`ifdef XM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 64
`endif
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            cReq_i,
   input  logic            dReq_i,
   input  logic            cRW_i,
   input  logic            dRW_i,
   input  logic            cByte_i,
   input  logic            dByte_i,
   input  logic [ADDR-1:0] cAdr_i,
   input  logic [ADDR-1:0] dAdr_i,
   input  logic [WORD-1:0] cWData_i,
   input  logic [WORD-1:0] dWData_i,
   output logic            cAck_o,
   output logic            dAck_o,
   output logic            cBusy_o,
   output logic            dBusy_o,
   output logic [WORD-1:0] cRData_o,
   output logic [WORD-1:0] dRData_o,
   output logic            memEn_o,
   output logic            memRW_o,
   output logic            memByte_o,
   output logic [ADDR-1:0] memAdr_o,
   output logic [WORD-1:0] memWData_o,
   input  logic [WORD-1:0] memRData_i,
   input  logic            memReady_i,
   output logic            err_o
);

   arb_state_e      state_r, state_s;
   arb_grant_e      grant_r;
   logic            start_s, done_s, pick_d_s, timeout_s;
   logic            sat_s, inc_s, clr_s, d_served_s;
   logic            mem_en_r, mem_rw_r, mem_byte_r;
   logic [ADDR-1:0] mem_adr_r;
   logic [WORD-1:0] mem_wdata_r, c_rdata_r, d_rdata_r;
   logic            c_ack_r, d_ack_r;

   assign pick_d_s   = d_priority(cReq_i, dReq_i, sat_s);
   // D is "granted" for the whole access it owns, including the RESP cycle.
   assign d_served_s = (state_r != IDLE) && (grant_r == GNT_D);
   assign inc_s      = dReq_i & ~d_served_s;
   assign clr_s      = start_s & pick_d_s;

   xm_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .inc    (inc_s),
      .clr    (clr_s),
      .sat    (sat_s)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; requester inputs only matter in IDLE.
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cReq_i || dReq_i) begin
               start_s = 1'b1;
               state_s = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (memReady_i || timeout_s) begin
               done_s  = 1'b1;
               state_s = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Memory strobes, grant, read-data capture and ack pulses.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         grant_r     <= GNT_C;
         mem_en_r    <= 1'b0;
         mem_rw_r    <= 1'b0;
         mem_byte_r  <= 1'b0;
         mem_adr_r   <= '0;
         mem_wdata_r <= '0;
         c_rdata_r   <= '0;
         d_rdata_r   <= '0;
         c_ack_r     <= 1'b0;
         d_ack_r     <= 1'b0;
      end else begin
         c_ack_r <= done_s & (grant_r == GNT_C);
         d_ack_r <= done_s & (grant_r == GNT_D);
         if (start_s) begin
            mem_en_r <= 1'b1;
            if (pick_d_s) begin
               grant_r     <= GNT_D;
               mem_rw_r    <= dRW_i;
               mem_byte_r  <= dByte_i;
               mem_adr_r   <= dAdr_i;
               mem_wdata_r <= dWData_i;
            end else begin
               grant_r     <= GNT_C;
               mem_rw_r    <= cRW_i;
               mem_byte_r  <= cByte_i;
               mem_adr_r   <= cAdr_i;
               mem_wdata_r <= cWData_i;
            end
         end else if (done_s) begin
            mem_en_r <= 1'b0;
            // An aborted access never has memReady_i, so RData stays put.
            if (memReady_i && (mem_rw_r == MEM_RD)) begin
               if (grant_r == GNT_D) begin
                  d_rdata_r <= memRData_i;
               end else begin
                  c_rdata_r <= memRData_i;
               end
            end
         end
      end
   end

`ifdef XM_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_r;
   logic            err_r;

   assign timeout_s = (to_cnt_r == TO_W'(TIMEOUT - 1)) & ~memReady_i;
   assign err_o     = err_r;

   // ACCESS cycle counter and the error pulse that accompanies an abort ack.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         to_cnt_r <= '0;
         err_r    <= 1'b0;
      end else begin
         err_r <= done_s & timeout_s;
         if (start_s) begin
            to_cnt_r <= '0;
         end else if ((state_r == ACCESS) && !done_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= to_cnt_r;
         end
      end
   end
`else
   assign timeout_s = 1'b0;
   assign err_o     = 1'b0;
`endif

   assign memEn_o    = mem_en_r;
   assign memRW_o    = mem_rw_r;
   assign memByte_o  = mem_byte_r;
   assign memAdr_o   = mem_adr_r;
   assign memWData_o = mem_wdata_r;
   assign cRData_o   = c_rdata_r;
   assign dRData_o   = d_rdata_r;
   assign cAck_o     = c_ack_r;
   assign dAck_o     = d_ack_r;
   assign cBusy_o    = cReq_i & ~c_ack_r;
   assign dBusy_o    = dReq_i & ~d_ack_r;

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Self-checking bench for xm_mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_xm_mem_arbiter;
   import xm_arb_pkg::*;

   localparam int WORD     = 16;
   localparam int ADDR     = 16;
   localparam int MAX_WAIT = 4;
`ifdef XM_ARB_TIMEOUT_EN
   localparam int TIMEOUT  = 8;
`endif

   logic            clk_i = 1'b0;
   logic            arst_i = 1'b0;
   logic            cReq_i = 1'b0, dReq_i = 1'b0, cRW_i = 1'b0, dRW_i = 1'b0;
   logic            cByte_i = 1'b0, dByte_i = 1'b0;
   logic [ADDR-1:0] cAdr_i = '0, dAdr_i = '0;
   logic [WORD-1:0] cWData_i = '0, dWData_i = '0, memRData_i = '0;
   logic            memReady_i = 1'b0;
   logic            cAck_o, dAck_o, cBusy_o, dBusy_o, memEn_o, memRW_o, memByte_o, err_o;
   logic [WORD-1:0] cRData_o, dRData_o, memWData_o;
   logic [ADDR-1:0] memAdr_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   xm_mem_arbiter #(
      .WORD(WORD), .ADDR(ADDR), .MAX_WAIT(MAX_WAIT)
`ifdef XM_ARB_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .cReq_i(cReq_i), .dReq_i(dReq_i), .cRW_i(cRW_i), .dRW_i(dRW_i),
      .cByte_i(cByte_i), .dByte_i(dByte_i), .cAdr_i(cAdr_i), .dAdr_i(dAdr_i),
      .cWData_i(cWData_i), .dWData_i(dWData_i),
      .cAck_o(cAck_o), .dAck_o(dAck_o), .cBusy_o(cBusy_o), .dBusy_o(dBusy_o),
      .cRData_o(cRData_o), .dRData_o(dRData_o),
      .memEn_o(memEn_o), .memRW_o(memRW_o), .memByte_o(memByte_o),
      .memAdr_o(memAdr_o), .memWData_o(memWData_o),
      .memRData_i(memRData_i), .memReady_i(memReady_i), .err_o(err_o)
   );

   // Reference model: one access in flight (or in its ack cycle) at a time.
   bit              m_active, m_resp, m_owner_d, m_en, m_rw, m_byte;
   bit              m_ack_c, m_ack_d, m_err;
   logic [ADDR-1:0] m_adr;
   logic [WORD-1:0] m_wd, m_rd_c, m_rd_d;
   int              m_starve, m_wait;

   task automatic model_reset();
      m_active = 0; m_resp = 0; m_owner_d = 0; m_en = 0; m_rw = 0; m_byte = 0;
      m_ack_c = 0; m_ack_d = 0; m_err = 0;
      m_adr = '0; m_wd = '0; m_rd_c = '0; m_rd_d = '0;
      m_starve = 0; m_wait = 0;
   endtask

   task automatic finish_access(input bit with_err);
      m_active = 0; m_resp = 1; m_en = 0;
      m_ack_c = !m_owner_d; m_ack_d = m_owner_d; m_err = with_err;
   endtask

   task automatic model_edge();
      bit d_served, took_d;
      if (!arst_i) begin
         model_reset();
         return;
      end
      d_served = (m_active || m_resp) && m_owner_d;
      took_d = 0;
      m_ack_c = 0; m_ack_d = 0; m_err = 0;
      if (m_resp) begin
         m_resp = 0;
      end else if (m_active) begin
         m_wait++;
         if (memReady_i) begin
            if (m_rw == MEM_RD) begin
               if (m_owner_d) m_rd_d = memRData_i;
               else           m_rd_c = memRData_i;
            end
            finish_access(0);
         end
`ifdef XM_ARB_TIMEOUT_EN
         else if (m_wait >= TIMEOUT) begin
            finish_access(1);
         end
`endif
      end else if (cReq_i || dReq_i) begin
         took_d = dReq_i && ((m_starve == MAX_WAIT) || !cReq_i);
         m_owner_d = took_d;
         m_rw   = took_d ? dRW_i    : cRW_i;
         m_byte = took_d ? dByte_i  : cByte_i;
         m_adr  = took_d ? dAdr_i   : cAdr_i;
         m_wd   = took_d ? dWData_i : cWData_i;
         m_en = 1; m_active = 1; m_wait = 0;
      end
      if (took_d)                                        m_starve = 0;
      else if (dReq_i && !d_served && m_starve < MAX_WAIT) m_starve++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("memEn", 32'(memEn_o), 32'(m_en));
      check("memRW", 32'(memRW_o), 32'(m_rw));
      check("memByte", 32'(memByte_o), 32'(m_byte));
      check("memAdr", 32'(memAdr_o), 32'(m_adr));
      check("memWData", 32'(memWData_o), 32'(m_wd));
      check("cAck", 32'(cAck_o), 32'(m_ack_c));
      check("dAck", 32'(dAck_o), 32'(m_ack_d));
      check("cRData", 32'(cRData_o), 32'(m_rd_c));
      check("dRData", 32'(dRData_o), 32'(m_rd_d));
      check("err", 32'(err_o), 32'(m_err));
      check("cBusy", 32'(cBusy_o), 32'(cReq_i & ~m_ack_c));
      check("dBusy", 32'(dBusy_o), 32'(dReq_i & ~m_ack_d));
      check("one_ack", 32'(cAck_o & dAck_o), 32'd0);
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n_ack, c_seen, d_seen, en_cycles;
      int         c_between[2];
      string      who[2];
      logic [15:0] ack_adr[2];

      model_reset();
      #12;
      compare_all();
      check("rst_memEn", 32'(memEn_o), 32'd0);
      arst_i = 1'b1;
      step(); step();

      // C read of 0x0040, memory answers the cycle after memEn rises.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0040;
      step();
      check("crd_en", 32'(memEn_o), 32'd1);
      check("crd_adr", 32'(memAdr_o), 32'h0040);
      memReady_i = 1'b1; memRData_i = 16'hBEEF;
      step();
      check("crd_ack", 32'(cAck_o), 32'd1);
      check("crd_data", 32'(cRData_o), 32'hBEEF);
      check("crd_busy", 32'(cBusy_o), 32'd0);
      cReq_i = 1'b0; memReady_i = 1'b0;
      step();
      check("crd_ack_once", 32'(cAck_o), 32'd0);
      check("crd_hold", 32'(cRData_o), 32'hBEEF);

      // Simultaneous requests: C write first, then D read.
      cReq_i = 1'b1; cRW_i = MEM_WR; cAdr_i = 16'h0010; cWData_i = 16'h1234;
      dReq_i = 1'b1; dRW_i = MEM_RD; dAdr_i = 16'h0020;
      memReady_i = 1'b1; memRData_i = 16'h5A5A;
      n_ack = 0;
      for (int i = 0; i < 12 && n_ack < 2; i++) begin
         step();
         if (cAck_o) begin who[n_ack] = "C"; ack_adr[n_ack] = memAdr_o; n_ack++; end
         if (dAck_o) begin who[n_ack] = "D"; ack_adr[n_ack] = memAdr_o; n_ack++; end
         if (m_ack_c) cReq_i = 1'b0;
         if (m_ack_d) dReq_i = 1'b0;
      end
      check("both_n_ack", 32'(n_ack), 32'd2);
      if (n_ack == 2) begin
         check("both_first_is_c", 32'(who[0] == "C"), 32'd1);
         check("both_second_is_d", 32'(who[1] == "D"), 32'd1);
         check("both_adr0", 32'(ack_adr[0]), 32'h0010);
         check("both_adr1", 32'(ack_adr[1]), 32'h0020);
      end
      check("both_d_rdata", 32'(dRData_o), 32'h5A5A);
      check("both_c_rdata_kept", 32'(cRData_o), 32'hBEEF);
      cReq_i = 1'b0; dReq_i = 1'b0; memReady_i = 1'b0;
      step();

      // Starvation: C asks back-to-back, D stays pending.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0100;
      dReq_i = 1'b1; dRW_i = MEM_RD; dAdr_i = 16'h0200;
      memReady_i = 1'b1; memRData_i = 16'h1111;
      c_seen = 0; d_seen = 0; c_between[0] = 0; c_between[1] = 0;
      for (int i = 0; i < 40 && d_seen < 2; i++) begin
         step();
         if (cAck_o) c_between[d_seen] = c_between[d_seen] + 1;
         if (dAck_o) d_seen++;
      end
      check("starve_d_served_twice", 32'(d_seen), 32'd2);
      check("starve_c_before_d1", 32'(c_between[0]), 32'd2);
      check("starve_c_before_d2", 32'(c_between[1]), 32'd2);
      check("starve_d_rdata", 32'(dRData_o), 32'h1111);
      cReq_i = 1'b0; dReq_i = 1'b0; memReady_i = 1'b0;
      step();

      // D byte write with slow memory; input changes during ACCESS are ignored.
      dReq_i = 1'b1; dRW_i = MEM_WR; dByte_i = 1'b1; dWData_i = 16'h00AB; dAdr_i = 16'h0031;
      step();
      for (int i = 0; i < 3; i++) begin
         check("dbw_byte", 32'(memByte_o), 32'd1);
         check("dbw_rw", 32'(memRW_o), 32'd1);
         check("dbw_wdata", 32'(memWData_o), 32'h00AB);
         dWData_i = 16'hFF00 + 16'(i);
         dAdr_i   = 16'h0F00 + 16'(i);
         step();
      end
      check("dbw_wdata_last", 32'(memWData_o), 32'h00AB);
      memReady_i = 1'b1; memRData_i = 16'hDEAD;
      step();
      check("dbw_ack", 32'(dAck_o), 32'd1);
      check("dbw_rdata_kept", 32'(dRData_o), 32'h1111);
      dReq_i = 1'b0; dByte_i = 1'b0; memReady_i = 1'b0;
      step();

      // Request dropped mid-ACCESS still completes and acks.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0077; memRData_i = 16'h7777;
      step();
      cReq_i = 1'b0;
      step();
      memReady_i = 1'b1;
      step();
      check("drop_ack", 32'(cAck_o), 32'd1);
      check("drop_rdata", 32'(cRData_o), 32'h7777);
      memReady_i = 1'b0;
      step();

`ifdef XM_ARB_TIMEOUT_EN
      // Memory never answers: abort after TIMEOUT ACCESS cycles.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0055; memRData_i = 16'h9999;
      en_cycles = 0;
      for (int i = 0; i < 20 && !cAck_o; i++) begin
         step();
         if (memEn_o) en_cycles++;
      end
      check("to_en_cycles", 32'(en_cycles), 32'd8);
      check("to_ack", 32'(cAck_o), 32'd1);
      check("to_err", 32'(err_o), 32'd1);
      check("to_rdata_kept", 32'(cRData_o), 32'h7777);
      cReq_i = 1'b0;
      step();
      cReq_i = 1'b1; cAdr_i = 16'h0056; memRData_i = 16'h5656;
      step();
      memReady_i = 1'b1;
      step();
      check("to_next_ack", 32'(cAck_o), 32'd1);
      check("to_next_err", 32'(err_o), 32'd0);
      check("to_next_rdata", 32'(cRData_o), 32'h5656);
      cReq_i = 1'b0; memReady_i = 1'b0;
      step();
`else
      // Without the timeout, ACCESS waits as long as the memory needs.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0055;
      en_cycles = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (memEn_o) en_cycles++;
      end
      check("wait_en_cycles", 32'(en_cycles), 32'd70);
      cReq_i = 1'b0; memReady_i = 1'b1; memRData_i = 16'h4242;
      step();
      check("wait_ack", 32'(cAck_o), 32'd1);
      check("wait_err", 32'(err_o), 32'd0);
      memReady_i = 1'b0;
      step();
`endif

      // Asynchronous reset in the middle of an access.
      cReq_i = 1'b1; cRW_i = MEM_RD; cAdr_i = 16'h0099;
      step();
      check("rst_pre_en", 32'(memEn_o), 32'd1);
      #2 arst_i = 1'b0;
      #1;
      model_reset();
      check("rst_async_en", 32'(memEn_o), 32'd0);
      check("rst_async_adr", 32'(memAdr_o), 32'd0);
      check("rst_async_crdata", 32'(cRData_o), 32'd0);
      compare_all();
      memReady_i = 1'b1;
      step();
      check("rst_no_ack", 32'(cAck_o), 32'd0);
      cReq_i = 1'b0; memReady_i = 1'b0;
      arst_i = 1'b1;
      step(); step();
      check("rst_idle_en", 32'(memEn_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
